accel_sequencer: RTL
====================

# accel_sequencer

Control sequencer that sits directly upstream of the accelerator top and drives all of its buffer, array and post-processing enables. It runs one matrix job per `start`:
- For each of `cfg_tiles` K-tiles: load a weight tile, preload it into the systolic array, then load and stream `cfg_rows` activation rows.
- Accumulate the tiles in the output buffer.
- Drain the result rows through ReLU/softmax.

It also tells the upstream memory feeder when `in_weight`/`in_act` must be valid.

## Interface
Parameters:
- `ARRAYWIDTH`, 8, array dimension; weight load and preload phases last this many cycles each.
- `ARRAY_LAT`, 16, cycles from first `input_buffer_out_en` to first valid `out_sum` row at the output buffer.
- `ROW_W`, 8, width of row count/index.
- `TILE_W`, 4, width of tile count/index.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  job request; accepted only in IDLE.
- `cfg_rows`  in  ROW_W  activation rows M per tile, legal range 1..2^ROW_W-1.
- `cfg_tiles`  in  TILE_W  number of K-tiles T, legal range 1..2^TILE_W-1.
- `cfg_relu`  in  1  apply ReLU on drain.
- `cfg_softmax`  in  1  apply softmax on drain.
- `busy`  out  1  high from the cycle after start is accepted until the DONE cycle, inclusive.
- `done`  out  1  one-cycle pulse at job end.
- `err`  out  1  one-cycle pulse when a start is rejected.
- `weight_req`, `act_req`  out  1  feeder must present `in_weight` / `in_act` in the same cycle.
- `input_buffer_load_en`, `input_buffer_out_en`, `input_buffer_delay_clear`  out  1 each  accelerator input buffer controls.
- `weight_buffer_load_en`, `weight_buffer_out_en`, `write_weight_en`  out  1 each  weight path controls.
- `output_buffer_load_en`, `output_buffer_out_en`, `output_buffer_load_clear`, `output_buffer_acc_enable`, `output_buffer_acc_clear`  out  1 each  output buffer controls.
- `relu_en`, `softmax_en`  out  1 each  post-processing enables.
- `tile_idx`  out  TILE_W  current tile.
- `row_idx`  out  ROW_W  phase-local cycle/row counter, for debug.

## Operation
- All outputs are registered (Moore, decoded from the next state). Reset value of every output is 0.
- **Config latching**
  - `cfg_*` are latched on an accepted start.
  - Config changes while busy are ignored.
- **Start rejection**
  - Start is rejected if `cfg_rows==0`, `cfg_tiles==0`, or `cfg_relu&cfg_softmax`.
  - On rejection: `err`=1 for one cycle, state stays IDLE, no other output toggles.
- **States**
  - IDLE: wait for `start`.
  - W_LOAD: ARRAYWIDTH cycles. `weight_buffer_load_en`=`weight_req`=1.
  - W_WRITE: ARRAYWIDTH cycles. `weight_buffer_out_en`=`write_weight_en`=1.
  - A_LOAD: M cycles. `input_buffer_load_en`=`act_req`=1.
  - A_STREAM: M+ARRAY_LAT cycles.
    - `input_buffer_out_en`=1 on stream cycles 0..M-1.
    - `output_buffer_load_en`=1 on stream cycles ARRAY_LAT..ARRAY_LAT+M-1.
    - `output_buffer_acc_enable` = `output_buffer_load_en` & (`tile_idx`!=0).
  - TILE_NEXT: 1 cycle.
    - `input_buffer_delay_clear`=`output_buffer_load_clear`=1.
    - `tile_idx`++ (cleared again on entry to DRAIN).
    - Goes to W_LOAD if `tile_idx`<T-1, else DRAIN.
  - DRAIN: M cycles. `output_buffer_out_en`=1, `relu_en`=`cfg_relu`, `softmax_en`=`cfg_softmax`.
  - DONE: 1 cycle. `done`=1, then IDLE.
- `output_buffer_acc_clear`=1 only in the first W_LOAD cycle of a job (tile 0).
- `row_idx` counts 0..len-1 within each timed state and resets on every state change.
- A mid-job `rst` asynchronously forces IDLE and all outputs to 0. Latched config and counters are cleared. No done pulse is issued.

## Timing
- Start is sampled at edge E. W_LOAD begins the following cycle (cycle 1).
- Cycles per tile: 2·ARRAYWIDTH + 2M + ARRAY_LAT + 1.
- `done` is high in cycle T·(2·ARRAYWIDTH+2M+ARRAY_LAT+1) + M + 1.
- There are no idle bubbles between phases or between tiles.
- `start` asserted in the DONE cycle is ignored. `start` is next accepted in IDLE, one cycle after DONE.
- Counter widths must hold M+ARRAY_LAT without overflow; use ROW_W+1 bits internally.

## Test plan
- **Basic two-tile job** (ARRAYWIDTH=4, ARRAY_LAT=8, M=3, T=2, relu=1). Start at cycle 0 ->
  - W_LOAD 1–4, W_WRITE 5–8, A_LOAD 9–11, A_STREAM 12–22, TILE_NEXT 23; tile 1 repeats over 24–46.
  - `output_buffer_load_en` high 20–22 and 43–45; `acc_enable` high only at 43–45.
  - `acc_clear` high only at cycle 1; DRAIN 47–49 with `relu_en`=1; `done` at 50.
- **Single tile, single row** (M=1, T=1) -> `acc_enable` never high; `done` at cycle 2·4+2+8+1+1+1=21.
- **Start rejection**
  - `cfg_rows`=0 -> `err` pulse next cycle, `busy`=0, all enables 0.
  - Repeat with `cfg_tiles`=0, and with relu=softmax=1.
- **Start while busy**: pulse start at cycles 5 and 50 of the basic job -> both ignored. No second job; `busy` drops after cycle 50.
- **Reset mid-job**: assert `rst` at cycle 30 of the basic job -> all outputs 0 immediately, no `done`. A fresh start then completes exactly as in the basic job.
- **Softmax drain** (cfg_softmax=1, relu=0) -> `softmax_en`=1 and `relu_en`=0 throughout DRAIN only.

Source files
------------

// File: rtl/accel_sequencer.sv
// Job sequencer for the systolic accelerator: per K-tile it loads/preloads weights,
// loads and streams activations, then drains the accumulated result rows.
module accel_sequencer #(
  parameter int ARRAYWIDTH = 8,
  parameter int ARRAY_LAT  = 16,
  parameter int ROW_W      = 8,
  parameter int TILE_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ROW_W-1:0]  cfg_rows,
  input  logic [TILE_W-1:0] cfg_tiles,
  input  logic              cfg_relu,
  input  logic              cfg_softmax,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              weight_req,
  output logic              act_req,
  output logic              input_buffer_load_en,
  output logic              input_buffer_out_en,
  output logic              input_buffer_delay_clear,
  output logic              weight_buffer_load_en,
  output logic              weight_buffer_out_en,
  output logic              write_weight_en,
  output logic              output_buffer_load_en,
  output logic              output_buffer_out_en,
  output logic              output_buffer_load_clear,
  output logic              output_buffer_acc_enable,
  output logic              output_buffer_acc_clear,
  output logic              relu_en,
  output logic              softmax_en,
  output logic [TILE_W-1:0] tile_idx,
  output logic [ROW_W-1:0]  row_idx,
  output logic [2:0]        dbg_state
);

  localparam int CW = ROW_W + 1;
  localparam logic [CW-1:0] AW_LAST = CW'(ARRAYWIDTH - 1);
  localparam logic [CW-1:0] LAT_C   = CW'(ARRAY_LAT);

  typedef enum logic [2:0] {
    S_IDLE, S_W_LOAD, S_W_WRITE, S_A_LOAD, S_A_STREAM, S_TILE_NEXT, S_DRAIN, S_DONE
  } state_t;

  typedef struct packed {
    logic busy;
    logic done;
    logic err;
    logic weight_req;
    logic act_req;
    logic ib_load;
    logic ib_out;
    logic ib_delay_clear;
    logic wb_load;
    logic wb_out;
    logic write_weight;
    logic ob_load;
    logic ob_out;
    logic ob_load_clear;
    logic ob_acc_en;
    logic ob_acc_clear;
    logic relu;
    logic softmax;
  } ctrl_t;

  state_t              r_state, w_next_state;
  logic [CW-1:0]       r_cnt, w_next_cnt;
  logic [TILE_W-1:0]   r_tile, w_next_tile;
  logic [ROW_W-1:0]    r_rows;
  logic [TILE_W-1:0]   r_tiles;
  logic                r_relu, r_softmax;
  ctrl_t               r_ctrl, w_ctrl;
  logic                w_cfg_ok, w_accept, w_reject;
  logic [CW-1:0]       w_rows_ext;

  assign w_cfg_ok   = (cfg_rows != '0) && (cfg_tiles != '0) && !(cfg_relu && cfg_softmax);
  assign w_rows_ext = {1'b0, r_rows};

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt + CW'(1);
    w_next_tile  = r_tile;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_next_cnt = '0;
        if (start) begin
          w_accept = w_cfg_ok;
          w_reject = !w_cfg_ok;
          if (w_cfg_ok) w_next_state = S_W_LOAD;
        end
      end
      S_W_LOAD:   if (r_cnt == AW_LAST) begin w_next_state = S_W_WRITE; w_next_cnt = '0; end
      S_W_WRITE:  if (r_cnt == AW_LAST) begin w_next_state = S_A_LOAD;  w_next_cnt = '0; end
      S_A_LOAD:   if (r_cnt == w_rows_ext - CW'(1)) begin w_next_state = S_A_STREAM; w_next_cnt = '0; end
      S_A_STREAM: if (r_cnt == LAT_C + w_rows_ext - CW'(1)) begin
        w_next_state = S_TILE_NEXT;
        w_next_cnt   = '0;
      end
      S_TILE_NEXT: begin
        w_next_cnt = '0;
        if (r_tile < r_tiles - TILE_W'(1)) begin
          w_next_state = S_W_LOAD;
          w_next_tile  = r_tile + TILE_W'(1);
        end else begin
          w_next_state = S_DRAIN;
          w_next_tile  = '0;
        end
      end
      S_DRAIN:    if (r_cnt == w_rows_ext - CW'(1)) begin w_next_state = S_DONE; w_next_cnt = '0; end
      S_DONE: begin
        w_next_state = S_IDLE;
        w_next_cnt   = '0;
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state so they line up with it cycle for cycle.
  always_comb begin
    w_ctrl      = '0;
    w_ctrl.busy = (w_next_state != S_IDLE);
    w_ctrl.err  = w_reject;
    unique case (w_next_state)
      S_W_LOAD: begin
        w_ctrl.wb_load      = 1'b1;
        w_ctrl.weight_req   = 1'b1;
        w_ctrl.ob_acc_clear = (w_next_cnt == '0) && (w_next_tile == '0);
      end
      S_W_WRITE: begin
        w_ctrl.wb_out       = 1'b1;
        w_ctrl.write_weight = 1'b1;
      end
      S_A_LOAD: begin
        w_ctrl.ib_load = 1'b1;
        w_ctrl.act_req = 1'b1;
      end
      S_A_STREAM: begin
        w_ctrl.ib_out    = (w_next_cnt < w_rows_ext);
        w_ctrl.ob_load   = (w_next_cnt >= LAT_C) && (w_next_cnt < LAT_C + w_rows_ext);
        w_ctrl.ob_acc_en = w_ctrl.ob_load && (w_next_tile != '0);
      end
      S_TILE_NEXT: begin
        w_ctrl.ib_delay_clear = 1'b1;
        w_ctrl.ob_load_clear  = 1'b1;
      end
      S_DRAIN: begin
        w_ctrl.ob_out  = 1'b1;
        w_ctrl.relu    = r_relu;
        w_ctrl.softmax = r_softmax;
      end
      S_DONE:  w_ctrl.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_tile    <= '0;
      r_rows    <= '0;
      r_tiles   <= '0;
      r_relu    <= 1'b0;
      r_softmax <= 1'b0;
      r_ctrl    <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_tile  <= w_next_tile;
      r_ctrl  <= w_ctrl;
      if (w_accept) begin
        r_rows    <= cfg_rows;
        r_tiles   <= cfg_tiles;
        r_relu    <= cfg_relu;
        r_softmax <= cfg_softmax;
      end
    end
  end

  assign busy                     = r_ctrl.busy;
  assign done                     = r_ctrl.done;
  assign err                      = r_ctrl.err;
  assign weight_req               = r_ctrl.weight_req;
  assign act_req                  = r_ctrl.act_req;
  assign input_buffer_load_en     = r_ctrl.ib_load;
  assign input_buffer_out_en      = r_ctrl.ib_out;
  assign input_buffer_delay_clear = r_ctrl.ib_delay_clear;
  assign weight_buffer_load_en    = r_ctrl.wb_load;
  assign weight_buffer_out_en     = r_ctrl.wb_out;
  assign write_weight_en          = r_ctrl.write_weight;
  assign output_buffer_load_en    = r_ctrl.ob_load;
  assign output_buffer_out_en     = r_ctrl.ob_out;
  assign output_buffer_load_clear = r_ctrl.ob_load_clear;
  assign output_buffer_acc_enable = r_ctrl.ob_acc_en;
  assign output_buffer_acc_clear  = r_ctrl.ob_acc_clear;
  assign relu_en                  = r_ctrl.relu;
  assign softmax_en               = r_ctrl.softmax;
  assign tile_idx                 = r_tile;
  assign row_idx                  = r_cnt[ROW_W-1:0];
  assign dbg_state                = r_state;

endmodule
